// File: rtl/cpu_exc_pkg.sv
// Shared exception-control definitions: FSM state encoding, MIPS ExcCode values
// and the default handler entry address.
package cpu_exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  // Address errors are the only causes that latch BadVAddr.
  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exc_epc_ctrl_if.sv
// Pipeline <-> exception controller bus: MEM-stage exception/ERET request in,
// flush and fetch-redirect handshake out.
interface exc_epc_ctrl_if;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_dslot;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic        redirect_ack;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output exc_valid, exc_code, exc_pc, exc_in_dslot, exc_badvaddr, eret, redirect_ack,
    input  flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_in_dslot, exc_badvaddr, eret, redirect_ack,
    output flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/epc_sel.sv
// EPC selection: a delay-slot fault restarts at the branch, one word earlier.
module epc_sel (
  input  logic [31:0] pc,
  input  logic        in_dslot,
  output logic [31:0] epc,
  output logic        bd
);
  assign epc = in_dslot ? (pc - 32'd4) : pc;
  assign bd  = in_dslot;
endmodule

// File: rtl/exc_epc_ctrl.sv
// Exception / ERET controller: captures EPC/Cause/Status, flushes the pipe and
// redirects fetch. Define EXC_BADVADDR_EN to implement the BadVAddr register.
module exc_epc_ctrl
  import cpu_exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  exc_epc_ctrl_if.slave     bus,
  output logic [31:0]       epc_o,
  output logic              cause_bd,
  output logic [4:0]        cause_exccode,
  output logic              status_exl,
  output logic [31:0]       badvaddr_o
);

  localparam logic [1:0] IDLE     = ST_IDLE;
  localparam logic [1:0] FLUSH    = ST_FLUSH;
  localparam logic [1:0] REDIRECT = ST_REDIRECT;

  logic [1:0]  state_reg, state_next;
  logic [31:0] redirect_pc_reg;
  logic [31:0] epc_reg;
  logic        bd_reg;
  logic [4:0]  exccode_reg;
  logic        exl_reg;
  logic [31:0] badvaddr_reg;
  logic [31:0] sel_epc;
  logic        sel_bd;
  logic        exc_take, eret_take;

  // Requests are only honoured in IDLE; exception has priority over ERET.
  assign exc_take  = (state_reg == IDLE) && bus.exc_valid;
  assign eret_take = (state_reg == IDLE) && bus.eret && !bus.exc_valid;

  epc_sel u_epc_sel (
    .pc       (bus.exc_pc),
    .in_dslot (bus.exc_in_dslot),
    .epc      (sel_epc),
    .bd       (sel_bd)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (exc_take || eret_take) state_next = FLUSH;
      FLUSH:    state_next = REDIRECT;
      REDIRECT: if (bus.redirect_ack) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      redirect_pc_reg <= 32'h0;
      epc_reg         <= 32'h0;
      bd_reg          <= 1'b0;
      exccode_reg     <= 5'h0;
      exl_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (exc_take) begin
        // Nested exception keeps the original restart point.
        if (!exl_reg) begin
          epc_reg <= sel_epc;
          bd_reg  <= sel_bd;
        end
        exl_reg         <= 1'b1;
        exccode_reg     <= bus.exc_code;
        redirect_pc_reg <= EXC_VECTOR;
      end else if (eret_take) begin
        exl_reg         <= 1'b0;
        redirect_pc_reg <= epc_reg;
      end
    end
  end

`ifdef EXC_BADVADDR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_reg <= 32'h0;
    end else if (exc_take && is_addr_err(bus.exc_code)) begin
      badvaddr_reg <= bus.exc_badvaddr;
    end
  end
`else
  logic unused_badvaddr;
  assign unused_badvaddr = ^bus.exc_badvaddr;
  assign badvaddr_reg    = 32'h0;
`endif

  assign bus.flush          = (state_reg == FLUSH);
  assign bus.redirect_valid = (state_reg == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_reg;

  assign epc_o         = epc_reg;
  assign cause_bd      = bd_reg;
  assign cause_exccode = exccode_reg;
  assign status_exl    = exl_reg;
  assign badvaddr_o    = badvaddr_reg;

endmodule

// File: tb/tb_exc_epc_ctrl.sv
// Directed bench for exc_epc_ctrl: redirect targets go through a scoreboard
// queue, CP0 state is compared against a small reference model.
module tb_exc_epc_ctrl;
  import cpu_exc_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exc_epc_ctrl_if bus ();
  logic [31:0] epc_o, badvaddr_o;
  logic        cause_bd, status_exl;
  logic [4:0]  cause_exccode;

  exc_epc_ctrl #(.EXC_VECTOR(VEC)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .epc_o         (epc_o),
    .cause_bd      (cause_bd),
    .cause_exccode (cause_exccode),
    .status_exl    (status_exl),
    .badvaddr_o    (badvaddr_o)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int check_cnt = 0;

  logic [31:0] sb_q[$];
  logic [31:0] exp_redir = 32'h0;
  logic [31:0] mon_exp;

  logic [31:0] m_epc = 32'h0;
  logic        m_bd = 1'b0;
  logic        m_exl = 1'b0;
  logic [4:0]  m_code = 5'h0;
  logic [31:0] m_bad = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_epc"},  epc_o, m_epc);
    chk({tag, "_bd"},   {31'b0, cause_bd}, {31'b0, m_bd});
    chk({tag, "_exl"},  {31'b0, status_exl}, {31'b0, m_exl});
    chk({tag, "_code"}, {27'b0, cause_exccode}, {27'b0, m_code});
    chk({tag, "_bad"},  badvaddr_o, m_bad);
  endtask

  task automatic clear_inputs();
    bus.exc_valid    = 1'b0;
    bus.eret         = 1'b0;
    bus.exc_pc       = 32'h0;
    bus.exc_code     = 5'h0;
    bus.exc_in_dslot = 1'b0;
    bus.exc_badvaddr = 32'h0;
  endtask

  // Called just after a posedge with the DUT idle; returns at the FLUSH negedge.
  task automatic issue(input logic do_exc, input logic do_eret, input logic [31:0] pc,
                       input logic [4:0] code, input logic dslot, input logic [31:0] bad);
    bus.exc_valid    = do_exc;
    bus.eret         = do_eret;
    bus.exc_pc       = pc;
    bus.exc_code     = code;
    bus.exc_in_dslot = dslot;
    bus.exc_badvaddr = bad;
    if (do_exc) begin
      if (!m_exl) begin
        m_epc = dslot ? pc - 32'd4 : pc;
        m_bd  = dslot;
      end
      m_exl  = 1'b1;
      m_code = code;
`ifdef EXC_BADVADDR_EN
      if (is_addr_err(code)) m_bad = bad;
`endif
      exp_redir = VEC;
    end else begin
      exp_redir = m_epc;
      m_exl = 1'b0;
    end
    sb_q.push_back(exp_redir);
    $display("issue exc=%0b eret=%0b pc=%h code=%0d dslot=%0b -> expect redirect %h",
             do_exc, do_eret, pc, code, dslot, exp_redir);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("flush_on", {31'b0, bus.flush}, 32'd1);
    chk("rv_in_flush", {31'b0, bus.redirect_valid}, 32'd0);
    chk_regs("captured");
  endtask

  // Runs from the FLUSH negedge through REDIRECT back to IDLE.
  task automatic phase(input int ack_delay, input logic inject);
    @(posedge clk); #1;
    if (inject) begin
      bus.exc_valid    = 1'b1;
      bus.eret         = 1'b1;
      bus.exc_pc       = 32'hFFFF_0000;
      bus.exc_code     = EXC_BP;
      bus.exc_badvaddr = 32'h0BAD_0BAD;
    end
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      chk("rv_wait", {31'b0, bus.redirect_valid}, 32'd1);
      chk("flush_wait", {31'b0, bus.flush}, 32'd0);
      chk("pc_hold", bus.redirect_pc, exp_redir);
      @(posedge clk); #1;
    end
    bus.redirect_ack = 1'b1;
    @(negedge clk);
    chk("rv_ack", {31'b0, bus.redirect_valid}, 32'd1);
    @(posedge clk); #1;
    bus.redirect_ack = 1'b0;
    clear_inputs();
    @(negedge clk);
    chk("idle_rv", {31'b0, bus.redirect_valid}, 32'd0);
    chk("idle_flush", {31'b0, bus.flush}, 32'd0);
    chk_regs("post");
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      check_cnt++;
      assert (!(bus.flush && bus.redirect_valid)) pass_cnt++;
      else begin
        fail_cnt++;
        $error("FAIL excl: got flush=%0b rv=%0b, want not both", bus.flush, bus.redirect_valid);
      end
      if (bus.redirect_valid && bus.redirect_ack) begin
        check_cnt++;
        assert (sb_q.size() != 0) pass_cnt++;
        else begin
          fail_cnt++;
          $error("FAIL sb_unexpected: got redirect %h, want none", bus.redirect_pc);
        end
        if (sb_q.size() != 0) begin
          mon_exp = sb_q.pop_front();
          chk("sb_redirect", bus.redirect_pc, mon_exp);
          $display("redirect handshake pc=%h", bus.redirect_pc);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    bus.redirect_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_flush", {31'b0, bus.flush}, 32'd0);
    chk("rst_rv", {31'b0, bus.redirect_valid}, 32'd0);
    chk("rst_rpc", bus.redirect_pc, 32'h0);
    chk_regs("rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // First exception, not in a delay slot
    issue(1'b1, 1'b0, 32'hBFC0_1000, EXC_SYS, 1'b0, 32'h0);
    chk("t1_epc", epc_o, 32'hBFC0_1000);
    phase(1, 1'b0);

    // Nested exception with EXL set: only ExcCode moves; immediate ack
    issue(1'b1, 1'b0, 32'h8000_0040, EXC_OV, 1'b0, 32'h0);
    chk("t3_epc", epc_o, 32'hBFC0_1000);
    chk("t3_code", {27'b0, cause_exccode}, 32'd12);
    phase(0, 1'b0);

    issue(1'b0, 1'b1, 32'h0, 5'h0, 1'b0, 32'h0);
    phase(2, 1'b0);

    // Delay-slot exception
    issue(1'b1, 1'b0, 32'hBFC0_1000, EXC_SYS, 1'b1, 32'h0);
    chk("t2_epc", epc_o, 32'hBFC0_0FFC);
    chk("t2_bd", {31'b0, cause_bd}, 32'd1);
    phase(0, 1'b0);

    issue(1'b0, 1'b1, 32'h0, 5'h0, 1'b0, 32'h0);
    phase(1, 1'b0);

    // AdEL exception; requests during REDIRECT must be ignored
    issue(1'b1, 1'b0, 32'hBFC0_1004, EXC_ADEL, 1'b0, 32'hDEAD_BEEF);
    phase(2, 1'b1);
    chk("inj_code", {27'b0, cause_exccode}, {27'b0, EXC_ADEL});

    // ERET with a 3-cycle ack delay
    chk("t4_epc", epc_o, 32'hBFC0_1004);
    issue(1'b0, 1'b1, 32'h0, 5'h0, 1'b0, 32'h0);
    chk("t4_exl", {31'b0, status_exl}, 32'd0);
    phase(3, 1'b0);

    // Exception and ERET together: exception wins
    issue(1'b1, 1'b1, 32'h8000_1000, EXC_RI, 1'b0, 32'h0);
    chk("both_epc", epc_o, 32'h8000_1000);
    phase(1, 1'b0);

    // Reset while a redirect is pending
    issue(1'b1, 1'b0, 32'h8000_2000, EXC_ADES, 1'b0, 32'h1234_5678);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_rv", {31'b0, bus.redirect_valid}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    m_epc = 32'h0; m_bd = 1'b0; m_exl = 1'b0; m_code = 5'h0; m_bad = 32'h0;
    sb_q.delete();
    chk("mid_rst_rv", {31'b0, bus.redirect_valid}, 32'd0);
    chk("mid_rst_flush", {31'b0, bus.flush}, 32'd0);
    chk("mid_rst_rpc", bus.redirect_pc, 32'h0);
    chk_regs("mid_rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_rv", {31'b0, bus.redirect_valid}, 32'd0);
    @(posedge clk); #1;

    issue(1'b1, 1'b0, 32'h0000_0100, EXC_INT, 1'b0, 32'h0);
    phase(0, 1'b0);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/exc_epc_ctrl.md
EXC_EPC_CTRL -- requirements
Module: exc_epc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC0_0380, exception handler entry address.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 exc_valid  in  1  MEM-stage instruction raises an exception this cycle.
REQ-005 exc_code  in  5  MIPS ExcCode of the faulting instruction.
REQ-006 exc_pc  in  32  PC of the faulting instruction.
REQ-007 exc_in_dslot  in  1  faulting instruction occupies a branch delay slot (delay-slot flag carried down the pipe).
REQ-008 exc_badvaddr  in  32  faulting virtual address.
REQ-009 eret  in  1  MEM-stage ERET commits this cycle.
REQ-010 redirect_ack  in  1  fetch accepts redirect_pc this cycle.
REQ-011 flush  out  1  kill all younger pipeline stages.
REQ-012 redirect_valid  out  1  redirect request to fetch.
REQ-013 redirect_pc  out  32  target fetch address.
REQ-014 epc_o  out  32  EPC register.
REQ-015 cause_bd  out  1  Cause.BD bit.
REQ-016 cause_exccode  out  5  Cause.ExcCode field.
REQ-017 status_exl  out  1  Status.EXL bit.
REQ-018 badvaddr_o  out  32  BadVAddr register.

Function
REQ-019 FSM states IDLE, FLUSH, REDIRECT; reset state IDLE.
REQ-020 IDLE + exc_valid -> FLUSH next cycle; capture event; redirect_pc <= EXC_VECTOR.
REQ-021 IDLE + eret (no exc_valid) -> FLUSH next cycle; redirect_pc <= epc_o; status_exl <= 0.
REQ-022 exc_valid and eret in same cycle: exception wins, eret ignored.
REQ-023 Exception with status_exl=0: epc_o <= exc_in_dslot ? exc_pc-32'd4 : exc_pc (modulo 2^32); cause_bd <= exc_in_dslot; status_exl <= 1.
REQ-024 Exception with status_exl=1: epc_o and cause_bd unchanged; cause_exccode still updated.
REQ-025 cause_exccode <= exc_code on every accepted exception.
REQ-026 FLUSH: flush=1 for exactly one cycle, then REDIRECT.
REQ-027 REDIRECT: redirect_valid=1, redirect_pc stable until redirect_ack=1; ack cycle -> IDLE next cycle.
REQ-028 redirect_ack already high on first REDIRECT cycle: one-cycle REDIRECT.
REQ-029 exc_valid/eret arriving in FLUSH or REDIRECT ignored (pipeline already killed).
REQ-030 flush and redirect_valid never asserted together; both 0 in IDLE.

Reset
REQ-031 resetn low, any state: immediately IDLE; flush, redirect_valid, cause_bd, status_exl = 0; redirect_pc, epc_o, badvaddr_o = 32'h0; cause_exccode = 5'h0.
REQ-032 Reset mid-REDIRECT drops pending redirect; no ack needed.

Configuration
REQ-033 Macro EXC_BADVADDR_EN defined: badvaddr_o <= exc_badvaddr on accepted exception with exc_code 5'h04 (AdEL) or 5'h05 (AdES), else held.
REQ-034 EXC_BADVADDR_EN undefined: badvaddr_o constant 32'h0, exc_badvaddr unused.

Structure
REQ-035 Shared package cpu_exc_pkg: FSM state enum, ExcCode constants (INT, ADEL, ADES, SYS, BP, RI, OV), default EXC_VECTOR.
REQ-036 One combinational sub-module epc_sel: (exc_pc, exc_in_dslot) -> (epc value, bd bit).

Verification
REQ-037 exc_valid, exc_pc=32'hBFC0_1000, in_dslot=0, code=8 -> epc_o=32'hBFC0_1000, cause_bd=0, exl=1, flush 1 cycle, redirect_pc=32'hBFC0_0380.
REQ-038 Same with in_dslot=1 -> epc_o=32'hBFC0_0FFC, cause_bd=1.
REQ-039 exl=1, second exception pc=32'h8000_0040, code=12 -> epc_o unchanged, cause_exccode=12.
REQ-040 eret with epc_o=32'hBFC0_1004, ack delayed 3 cycles -> redirect_pc held 3 cycles, exl=0, IDLE after ack.
REQ-041 exc_valid and eret same cycle -> exception path only; exc_valid during REDIRECT -> ignored.
REQ-042 resetn low during REDIRECT -> redirect_valid=0 same cycle, all outputs at reset values.
